// File: rtl/rll_pkg.sv
// rtl/rll_pkg.sv - shared state type and index/width helpers for the sequential key bank.
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ARMED  = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned key_w);
    return $clog2(key_w + 1);
  endfunction

  function automatic int unsigned key_idx(input int unsigned i, input int unsigned key_w);
    return i % key_w;
  endfunction

endpackage

// File: rtl/rll_key_shift.sv
// rtl/rll_key_shift.sv - serial shadow register, bit counter and full flag for the key bank.
module rll_key_shift
  import rll_pkg::*;
#(
  parameter int KEY_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic             i_abort,
  input  logic             i_clear,
  output logic [KEY_W-1:0] o_shadow,
  output logic             o_full
);

  localparam int CNT_W = int'(cnt_w(KEY_W));

  logic [KEY_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_count;

  // The accept that lands the last bit is the one that requests the commit.
  assign o_full   = i_accept && (r_count == CNT_W'(KEY_W - 1));
  assign o_shadow = r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_shadow <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_accept) begin
      for (int j = 0; j < KEY_W; j++) begin
        if (r_count == CNT_W'(j)) r_shadow[j] <= i_bit;
      end
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rll_seq_key_bank.sv
// rtl/rll_seq_key_bank.sv - serially loaded key with atomic commit driving a registered XOR/XNOR gate bank.
// Define RLL_KEY_OTP_EN to make the key one-time-programmable (no reload after the first commit).
module rll_seq_key_bank
  import rll_pkg::*;
#(
  parameter int               KEY_W    = 16,
  parameter int               DATA_W   = 16,
  parameter logic [KEY_W-1:0] POLARITY = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_sdi,
  input  logic              i_key_valid,
  output logic              o_key_ready,
  input  logic              i_key_abort,
  output logic              o_key_commit,
  output logic              o_key_loaded,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_valid,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_out_valid
);

  state_t            r_state;
  state_t            w_next;
  logic              w_ready;
  logic              w_abort;
  logic              w_accept;
  logic              w_full;
  logic [KEY_W-1:0]  w_shadow;
  logic [KEY_W-1:0]  r_key;
  logic              r_commit;
  logic              r_loaded;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_out_valid;

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      LOAD:    w_ready = 1'b1;
`ifdef RLL_KEY_OTP_EN
      ARMED:   w_ready = 1'b0;
`else
      ARMED:   w_ready = 1'b1;
`endif
      default: w_ready = 1'b0;
    endcase
  end

  // Abort only means something while a partial key is in the shadow; it beats a same-cycle bit.
  assign w_abort  = i_key_abort && (r_state == LOAD);
  assign w_accept = i_key_valid && w_ready && !w_abort;

  rll_key_shift #(
    .KEY_W(KEY_W)
  ) u_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_accept(w_accept),
    .i_bit   (i_key_sdi),
    .i_abort (w_abort),
    .i_clear (r_state == COMMIT),
    .o_shadow(w_shadow),
    .o_full  (w_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ARMED: begin
        if (w_full)        w_next = COMMIT;
        else if (w_accept) w_next = LOAD;
      end
      LOAD: begin
        if (w_abort)     w_next = r_loaded ? ARMED : IDLE;
        else if (w_full) w_next = COMMIT;
      end
      COMMIT:  w_next = ARMED;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key    <= '0;
      r_commit <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_commit <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_key    <= w_shadow;
        r_loaded <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DATA_W; g++) begin : g_gate
    assign w_mask[g] = r_key[key_idx(g, KEY_W)] ^ POLARITY[key_idx(g, KEY_W)];
  end

  // The key register and data_out update on the same edge, so COMMIT-cycle data sees the old key.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= i_data_valid;
      if (i_data_valid) r_data_out <= i_data_in ^ w_mask;
    end
  end

  assign o_key_ready      = w_ready;
  assign o_key_commit     = r_commit;
  assign o_key_loaded     = r_loaded;
  assign o_data_out       = r_data_out;
  assign o_data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_rll_seq_key_bank.sv
// tb/tb_rll_seq_key_bank.sv - directed and randomized checks of rll_seq_key_bank against a queue-based model.
module tb_rll_seq_key_bank;

  localparam int         KEY_W  = 4;
  localparam int         DATA_W = 8;
  localparam logic [3:0] POL    = 4'b1010;
`ifdef RLL_KEY_OTP_EN
  localparam bit OTP = 1'b1;
`else
  localparam bit OTP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_sdi = 1'b0, key_valid = 1'b0, key_abort = 1'b0, data_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        key_ready, key_commit, key_loaded, data_out_valid;
  logic [7:0]  data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rll_seq_key_bank #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .POLARITY(POL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key_sdi(key_sdi), .i_key_valid(key_valid),
    .o_key_ready(key_ready), .i_key_abort(key_abort), .o_key_commit(key_commit),
    .o_key_loaded(key_loaded), .i_data_in(data_in), .i_data_valid(data_valid),
    .o_data_out(data_out), .o_data_out_valid(data_out_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: collected bits in a queue, one busy cycle after the last bit.
  bit         m_init = 1'b0;
  logic [3:0] m_key;
  bit         m_loaded, m_busy, m_commit, m_dvalid;
  logic [7:0] m_dout;
  logic       m_bits[$];

  function automatic bit m_ready();
    return !m_busy && !(OTP && m_loaded);
  endfunction

  function automatic logic [7:0] gate(input logic [7:0] d, input logic [3:0] k);
    logic [7:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[i] ^ k[i % KEY_W] ^ POL[i % KEY_W];
    return r;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      m_init = 1'b1; m_key = '0; m_loaded = 0; m_busy = 0; m_commit = 0;
      m_dvalid = 0; m_dout = '0; m_bits.delete();
    end else begin
      rdy      = m_ready();
      m_dvalid = data_valid;
      if (data_valid) m_dout = gate(data_in, m_key);
      m_commit = m_busy;
      if (m_busy) begin
        for (int j = 0; j < KEY_W; j++) m_key[j] = m_bits[j];
        m_loaded = 1'b1;
        m_busy   = 1'b0;
        m_bits.delete();
      end else if (key_abort && m_bits.size() > 0) begin
        m_bits.delete();
      end else if (key_valid && rdy) begin
        m_bits.push_back(key_sdi);
        if (m_bits.size() == KEY_W) m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_ready",  key_ready,      m_ready());
      chk("model_commit", key_commit,     m_commit);
      chk("model_loaded", key_loaded,     m_loaded);
      chk("model_dvalid", data_out_valid, m_dvalid);
      chk("model_dout",   data_out,       m_dout);
    end
  end

  task automatic cyc(input logic v, input logic b, input logic a, input logic [7:0] d, input logic dv);
    key_valid = v; key_sdi = b; key_abort = a; data_in = d; data_valid = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int commits, gaps;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", key_ready, 1'b1);
    chk("rst_loaded", key_loaded, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    cyc(0, 0, 0, 8'hFF, 1);
    chk("nokey_ff", data_out, 8'h55);
    chk("nokey_valid", data_out_valid, 1'b1);

    cyc(1, 0, 0, 8'hFF, 1); cyc(1, 1, 0, 8'hFF, 1); cyc(1, 0, 0, 8'hFF, 1); cyc(1, 1, 0, 8'hFF, 1);
    chk("commit_gap", key_ready, 1'b0);
    cyc(0, 0, 0, 8'hFF, 1);
    chk("commit_pulse", key_commit, 1'b1);
    chk("commit_loaded", key_loaded, 1'b1);
    chk("commit_cycle_oldkey", data_out, 8'h55);
    cyc(0, 0, 0, 8'hFF, 1);
    chk("newkey_ff", data_out, 8'hFF);
    chk("commit_once", key_commit, 1'b0);

`ifndef RLL_KEY_OTP_EN
    cyc(1, 1, 0, 8'h00, 0); cyc(1, 0, 0, 8'h00, 0); cyc(0, 0, 1, 8'h00, 0);
    chk("abort_armed_ready", key_ready, 1'b1);
    cyc(0, 0, 0, 8'h3C, 1);
    chk("abort_keeps_key", data_out, 8'h3C);
    chk("abort_no_commit", key_commit, 1'b0);

    cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 1, 8'h00, 0);
    chk("abort4_no_commit_state", key_ready, 1'b1);
    cyc(0, 0, 0, 8'h00, 0);
    chk("abort4_no_pulse", key_commit, 1'b0);
    cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 0, 8'h00, 0); cyc(1, 1, 0, 8'h00, 0);
    chk("reload_gap", key_ready, 1'b0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("reload_pulse", key_commit, 1'b1);
    chk("reload_oldkey", data_out, 8'h00);
    chk("model_key_pin", m_key, 4'b1111);
    cyc(0, 0, 0, 8'h00, 1);
    chk("reload_newkey", data_out, 8'h55);
`endif

    commits = 0; gaps = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, i[0], 0, 8'h00, 0);
      if (!key_ready) gaps++;
      if (key_commit) commits++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 8'h00, 0);
      if (key_commit) commits++;
    end
    chk("stream12_commits", commits, OTP ? 0 : 2);
    chk("stream12_gaps", gaps, OTP ? 12 : 2);

    rst = 1'b1;
    cyc(0, 0, 0, 8'h00, 0);
    rst = 1'b0;
    chk("midload_rst_loaded", key_loaded, 1'b0);
    cyc(0, 0, 0, 8'hFF, 1);
    chk("midload_rst_ff", data_out, 8'h55);

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 11) == 0), 8'($urandom), $urandom_range(0, 1));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
